fan_mode_controller: RTL and testbench
======================================

Name: fan_mode_controller

Overview:
- Top-level sequencer for the PWM fan project.
- Decodes debounced button pulses into fan speed selection and timer configuration, and drives the countdown timer's control inputs (mode, inc, dec, start, 1 Hz tick).
- Turns the fan off when the timer expires.
- Sits between the button debouncers and the countdown timer / PWM generator.

Parameters:
- CLK_FREQ_HZ, 100_000_000, clk cycles per tick_1hz pulse.
- DUTY_L1, 7'd30, duty percent at speed level 1.
- DUTY_L2, 7'd60, duty percent at speed level 2.
- DUTY_L3, 7'd90, duty percent at speed level 3.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, synchronous, active-high.
- power_btn  in  1  single-cycle pulse; fan on/off toggle.
- mode_btn  in  1  single-cycle pulse; mode step.
- up_btn  in  1  single-cycle pulse.
- down_btn  in  1  single-cycle pulse.
- start_btn  in  1  single-cycle pulse.
- timer_running  in  1  running flag from the countdown timer.
- timer_mode  out  1  enables the countdown timer; low clears it.
- t_inc  out  1  1-cycle increment pulse to the timer.
- t_dec  out  1  1-cycle decrement pulse to the timer.
- t_start  out  1  1-cycle start pulse to the timer.
- tick_1hz  out  1  1-cycle pulse every CLK_FREQ_HZ cycles.
- duty  out  7  PWM duty percent, 0..100.
- fan_on  out  1  fan enabled.
- state_code  out  2  current state, for the display mux.
- timer_done  out  1  1-cycle pulse on timer expiry.

Behaviour:
- All outputs are registered.
- Reset (sync, rst=1 at a clk edge) values:
  - state = S_OFF, speed = 1, divider = 0.
  - All pulse outputs 0; timer_mode 0; duty 0; fan_on 0; state_code 0.
- States (state_code): S_OFF=0, S_SPEED=1, S_TSET=2, S_TRUN=3.
- Input priority per cycle: power_btn > mode_btn > start_btn > up/down.
  - up_btn and down_btn in the same cycle: both ignored.
- Transitions:
  - S_OFF:
    - power_btn -> S_SPEED, speed keeps its last value (1 after reset).
    - All other buttons ignored.
  - S_SPEED:
    - up/down adjust speed, saturating at 1..3 (no wrap).
    - mode_btn -> S_TSET.
    - power_btn -> S_OFF.
  - S_TSET:
    - timer_mode=1.
    - up/down are forwarded as t_inc/t_dec one cycle later; speed is unchanged.
    - start_btn: t_start pulses the next cycle and the divider clears to 0.
    - timer_running observed 1 -> S_TRUN.
    - If the timer ignores start (set value 0), remain in S_TSET.
    - mode_btn -> S_SPEED (timer_mode drops, timer clears).
    - power_btn -> S_OFF.
  - S_TRUN:
    - timer_mode=1; up/down adjust speed as in S_SPEED.
    - Falling edge of timer_running (registered previous value 1, current 0) -> S_OFF, timer_done=1 for exactly one cycle.
    - mode_btn -> S_SPEED, cancels the timer, no timer_done.
    - power_btn -> S_OFF, cancels the timer, no timer_done.
- timer_mode is 1 only in S_TSET and S_TRUN; it deasserts the same cycle the state leaves them.
  - The resulting timer_running fall is not treated as expiry, because the state is no longer S_TRUN.
- duty and fan_on:
  - duty = 0 and fan_on = 0 in S_OFF.
  - Otherwise duty = DUTY_Ln for the current speed and fan_on = 1.
  - Both update one cycle after the state or speed change.
- tick_1hz:
  - Divider counts 0..CLK_FREQ_HZ-1 continuously, all states; tick_1hz=1 in the cycle the count reaches CLK_FREQ_HZ-1, then the count wraps to 0.
  - Forwarded t_start clears the divider, so the first second after start is full length.
  - Divider width = $clog2(CLK_FREQ_HZ).
- t_inc/t_dec/t_start are never asserted outside S_TSET.
- Reset mid-countdown: everything returns to reset values next edge; timer_mode=0 clears the timer.

Decomposition:
- Package fan_ctrl_pkg:
  - State encoding localparams (S_OFF..S_TRUN).
  - Speed limits SPEED_MIN=1, SPEED_MAX=3.
  - Default duty constants.
- Sub-module tick_gen, parameter CLK_FREQ_HZ; ports clk, rst, clr, tick.
- The FSM, speed register and output registers stay in fan_mode_controller.

Test Plan:
All scenarios use CLK_FREQ_HZ=10 and a behavioural timer model (1-cycle start latency).

1. Reset, power_btn -> state_code 1, fan_on=1, duty=30; up x3 -> duty 90 (saturates at 3); down x5 -> duty 30.
2. From S_SPEED: mode_btn, up x3, start_btn -> t_inc pulses 3 times; t_start one cycle after start_btn; divider cleared; state 3 after timer_running=1; tick_1hz exactly 10 cycles after t_start.
3. In S_TRUN: timer model drops timer_running -> state 0, timer_done high exactly 1 cycle, duty=0, timer_mode=0.
4. In S_TRUN: mode_btn -> state 1, timer_mode=0, timer_done stays 0, duty unchanged.
5. Simultaneous events: power_btn+mode_btn same cycle in S_SPEED -> S_OFF; up+down same cycle -> speed unchanged; start_btn in S_TSET with timer set 0 -> remains state 2.
6. rst asserted mid-S_TRUN -> next edge all outputs 0, state 0; power_btn then gives duty=30 (speed back to 1).

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// Shared encodings and limits for the fan mode controller.
package fan_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_OFF   = 2'd0;
  localparam state_t S_SPEED = 2'd1;
  localparam state_t S_TSET  = 2'd2;
  localparam state_t S_TRUN  = 2'd3;

  localparam logic [1:0] SPEED_MIN = 2'd1;
  localparam logic [1:0] SPEED_MAX = 2'd3;

  localparam logic [6:0] DUTY_L1_DEF = 7'd30;
  localparam logic [6:0] DUTY_L2_DEF = 7'd60;
  localparam logic [6:0] DUTY_L3_DEF = 7'd90;

  // Saturating speed step; callers guarantee up and dn are never both set.
  function automatic logic [1:0] speed_step(input logic [1:0] speed,
                                            input logic up,
                                            input logic dn);
    if (up && (speed < SPEED_MAX)) return speed + 2'd1;
    if (dn && (speed > SPEED_MIN)) return speed - 2'd1;
    return speed;
  endfunction

endpackage

// File: rtl/fan_mode_controller_if.sv
// Button, countdown-timer and PWM signals around the fan mode controller.
interface fan_mode_controller_if;
  logic       power_btn;
  logic       mode_btn;
  logic       up_btn;
  logic       down_btn;
  logic       start_btn;
  logic       timer_running;
  logic       timer_mode;
  logic       t_inc;
  logic       t_dec;
  logic       t_start;
  logic       tick_1hz;
  logic [6:0] duty;
  logic       fan_on;
  logic [1:0] state_code;
  logic       timer_done;

  // master: debouncers + countdown timer + PWM side; slave: the controller
  modport master (
    output power_btn, mode_btn, up_btn, down_btn, start_btn, timer_running,
    input  timer_mode, t_inc, t_dec, t_start, tick_1hz, duty, fan_on,
           state_code, timer_done
  );

  modport slave (
    input  power_btn, mode_btn, up_btn, down_btn, start_btn, timer_running,
    output timer_mode, t_inc, t_dec, t_start, tick_1hz, duty, fan_on,
           state_code, timer_done
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running 1 Hz tick divider; clr restarts a full-length period.
module tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] count_reg, count_next;
  logic          tick_reg;

  always_comb begin
    if (clr || (count_reg == LAST)) count_next = '0;
    else                            count_next = count_reg + CW'(1);
  end

  // tick is high exactly while the counter holds its last value
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tick_reg  <= (count_next == LAST);
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/fan_mode_controller.sv
// Top-level sequencer for the PWM fan: turns button pulses into speed and
// countdown-timer control, and switches the fan off when the timer expires.
module fan_mode_controller
  import fan_ctrl_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 100_000_000,
  parameter logic [6:0] DUTY_L1     = DUTY_L1_DEF,
  parameter logic [6:0] DUTY_L2     = DUTY_L2_DEF,
  parameter logic [6:0] DUTY_L3     = DUTY_L3_DEF
) (
  input logic                  clk,
  input logic                  rst,
  fan_mode_controller_if.slave bus
);

  state_t     state_reg, state_next;
  logic [1:0] speed_reg, speed_next;
  logic       run_prev_reg;
  logic       timer_mode_reg, timer_mode_next;
  logic       t_inc_reg, t_inc_next;
  logic       t_dec_reg, t_dec_next;
  logic       t_start_reg, t_start_next;
  logic       timer_done_reg, timer_done_next;
  logic       fan_on_reg, fan_on_next;
  logic [6:0] duty_reg, duty_next;
  logic       tick_w;

  // Button priority: power > mode > start > up/down (up+down together cancel)
  logic power_sel, mode_sel, start_sel, step_up, step_dn, expiry;
  assign power_sel = bus.power_btn;
  assign mode_sel  = !bus.power_btn && bus.mode_btn;
  assign start_sel = !bus.power_btn && !bus.mode_btn && bus.start_btn;
  assign step_up   = !bus.power_btn && !bus.mode_btn && !bus.start_btn
                     && bus.up_btn && !bus.down_btn;
  assign step_dn   = !bus.power_btn && !bus.mode_btn && !bus.start_btn
                     && bus.down_btn && !bus.up_btn;
  assign expiry    = run_prev_reg && !bus.timer_running;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_OFF;
      speed_reg      <= SPEED_MIN;
      run_prev_reg   <= 1'b0;
      timer_mode_reg <= 1'b0;
      t_inc_reg      <= 1'b0;
      t_dec_reg      <= 1'b0;
      t_start_reg    <= 1'b0;
      timer_done_reg <= 1'b0;
      fan_on_reg     <= 1'b0;
      duty_reg       <= 7'd0;
    end else begin
      state_reg      <= state_next;
      speed_reg      <= speed_next;
      run_prev_reg   <= bus.timer_running;
      timer_mode_reg <= timer_mode_next;
      t_inc_reg      <= t_inc_next;
      t_dec_reg      <= t_dec_next;
      t_start_reg    <= t_start_next;
      timer_done_reg <= timer_done_next;
      fan_on_reg     <= fan_on_next;
      duty_reg       <= duty_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    speed_next = speed_reg;
    case (state_reg)
      S_OFF: begin
        if (power_sel) state_next = S_SPEED;
      end
      S_SPEED: begin
        if (power_sel)     state_next = S_OFF;
        else if (mode_sel) state_next = S_TSET;
        else               speed_next = speed_step(speed_reg, step_up, step_dn);
      end
      S_TSET: begin
        // a start the timer ignores (set value 0) never raises running
        if (power_sel)              state_next = S_OFF;
        else if (mode_sel)          state_next = S_SPEED;
        else if (bus.timer_running) state_next = S_TRUN;
      end
      S_TRUN: begin
        if (power_sel)     state_next = S_OFF;
        else if (mode_sel) state_next = S_SPEED;
        else begin
          speed_next = speed_step(speed_reg, step_up, step_dn);
          if (expiry) state_next = S_OFF;
        end
      end
      default: state_next = S_OFF;
    endcase
  end

  // Registered-output next values; duty/fan_on follow the current state and
  // speed, so they land one cycle after any change.
  always_comb begin
    timer_mode_next = (state_next == S_TSET) || (state_next == S_TRUN);
    t_inc_next      = (state_reg == S_TSET) && step_up;
    t_dec_next      = (state_reg == S_TSET) && step_dn;
    t_start_next    = (state_reg == S_TSET) && start_sel;
    timer_done_next = (state_reg == S_TRUN) && !power_sel && !mode_sel && expiry;
    fan_on_next     = (state_reg != S_OFF);
    duty_next       = 7'd0;
    if (state_reg != S_OFF) begin
      case (speed_reg)
        2'd2:    duty_next = DUTY_L2;
        2'd3:    duty_next = DUTY_L3;
        default: duty_next = DUTY_L1;
      endcase
    end
  end

  tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (t_start_reg),
    .tick (tick_w)
  );

  assign bus.timer_mode = timer_mode_reg;
  assign bus.t_inc      = t_inc_reg;
  assign bus.t_dec      = t_dec_reg;
  assign bus.t_start    = t_start_reg;
  assign bus.tick_1hz   = tick_w;
  assign bus.duty       = duty_reg;
  assign bus.fan_on     = fan_on_reg;
  assign bus.state_code = state_reg;
  assign bus.timer_done = timer_done_reg;

endmodule

// File: tb/tb_fan_mode_controller.sv
// Bench for fan_mode_controller: directed scenarios plus random buttons,
// checked every cycle against a behavioural model and a countdown-timer model.
module tb_fan_mode_controller;

  localparam int N = 10;
  localparam logic [4:0] IDLE = 5'b00000;  // {power, mode, start, up, down}
  localparam logic [4:0] PWR  = 5'b10000;
  localparam logic [4:0] MOD  = 5'b01000;
  localparam logic [4:0] STA  = 5'b00100;
  localparam logic [4:0] UPB  = 5'b00010;
  localparam logic [4:0] DNB  = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fan_mode_controller_if bus();

  fan_mode_controller #(.CLK_FREQ_HZ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference: speed level, mode number, seconds divider.
  int         duty_tbl [4] = '{0, 30, 60, 90};
  int         m_state, m_speed, m_div;
  bit         m_prev_run;
  logic       exp_mode, exp_inc, exp_dec, exp_start, exp_tick, exp_fan, exp_done;
  logic [6:0] exp_duty;
  logic [1:0] exp_state;

  // Values seen just before the active edge
  logic [4:0] c_b;
  logic       c_rst, c_run, c_tmode, c_inc, c_dec, c_start, c_tick;

  // Countdown timer environment model (seconds left, running flag)
  int tval;
  bit trun;

  function automatic logic [15:0] dut_vec();
    return {bus.timer_mode, bus.t_inc, bus.t_dec, bus.t_start, bus.tick_1hz,
            bus.duty, bus.fan_on, bus.state_code, bus.timer_done};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {exp_mode, exp_inc, exp_dec, exp_start, exp_tick,
            exp_duty, exp_fan, exp_state, exp_done};
  endfunction

  task automatic model_step();
    bit pw, md, st, up, dn;
    int adj, nxt;
    {pw, md, st, up, dn} = c_b;
    if (c_rst) begin
      m_state = 0; m_speed = 1; m_div = 0; m_prev_run = 0;
      {exp_mode, exp_inc, exp_dec, exp_start, exp_tick, exp_fan, exp_done} = '0;
      exp_duty = '0; exp_state = '0;
    end else begin
      m_div    = exp_start ? 0 : (m_div + 1) % N;
      exp_tick = (m_div == N - 1);
      adj = 0;
      if (!pw && !md && !st && (up != dn)) adj = up ? 1 : -1;
      exp_duty  = (m_state == 0) ? 7'd0 : 7'(duty_tbl[m_speed]);
      exp_fan   = (m_state != 0);
      exp_inc   = (m_state == 2) && (adj == 1);
      exp_dec   = (m_state == 2) && (adj == -1);
      exp_start = (m_state == 2) && !pw && !md && st;
      exp_done  = (m_state == 3) && !pw && !md && m_prev_run && !c_run;
      nxt = m_state;
      if (pw) nxt = (m_state == 0) ? 1 : 0;
      else if (m_state == 0) nxt = 0;
      else if (md) nxt = (m_state == 1) ? 2 : 1;
      else begin
        if (m_state != 2) begin
          m_speed = m_speed + adj;
          if (m_speed > 3) m_speed = 3;
          if (m_speed < 1) m_speed = 1;
        end
        if (m_state == 2 && c_run) nxt = 3;
        if (m_state == 3 && m_prev_run && !c_run) nxt = 0;
      end
      m_state    = nxt;
      m_prev_run = c_run;
      exp_mode   = (m_state >= 2);
      exp_state  = 2'(m_state);
    end
  endtask

  task automatic timer_step();
    if (c_rst || c_tmode !== 1'b1) begin
      tval = 0; trun = 0;
    end else if (trun) begin
      if (c_tick) begin
        tval--;
        if (tval <= 0) begin tval = 0; trun = 0; end
      end
    end else begin
      if (c_inc) tval++;
      if (c_dec && tval > 0) tval--;
      if (c_start && tval > 0) trun = 1;
    end
    bus.timer_running = trun;
  endtask

  // One clock: drive buttons, advance DUT, model and timer; inputs change #1 after the edge.
  task automatic cyc(input logic [4:0] b);
    {bus.power_btn, bus.mode_btn, bus.start_btn, bus.up_btn, bus.down_btn} = b;
    c_b = b; c_rst = rst; c_run = bus.timer_running;
    c_tmode = bus.timer_mode; c_inc = bus.t_inc; c_dec = bus.t_dec;
    c_start = bus.t_start; c_tick = bus.tick_1hz;
    @(posedge clk);
    #1;
    model_step();
    timer_step();
    {bus.power_btn, bus.mode_btn, bus.start_btn, bus.up_btn, bus.down_btn} = IDLE;
    if (b != IDLE || c_rst)
      $display("txn t=%0t rst=%0b btn=%05b -> state=%0d duty=%0d tmode=%0b run=%0b",
               $time, c_rst, b, bus.state_code, bus.duty, bus.timer_mode, trun);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(IDLE);
    cyc(IDLE);
    total++; if (dut_vec() !== 16'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0000", dut_vec()); end
    rst = 1'b0;
    cyc(IDLE);
    total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_speed();
    cyc(PWR);
    total++; if (bus.state_code !== 2'd1 || bus.fan_on !== 1'b0) begin bad++; $display("FAIL power_on_state got=%0d/%0b exp=1/0", bus.state_code, bus.fan_on); end
    cyc(IDLE);
    total++; if (bus.duty !== 7'd30 || bus.fan_on !== 1'b1) begin bad++; $display("FAIL power_on_duty got=%0d/%0b exp=30/1", bus.duty, bus.fan_on); end
    for (int i = 0; i < 3; i++) begin
      cyc(UPB);
      cyc(IDLE);
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL speed_up_model got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    total++; if (bus.duty !== 7'd90) begin bad++; $display("FAIL speed_sat_high got=%0d exp=90", bus.duty); end
    for (int i = 0; i < 5; i++) begin
      cyc(DNB);
      cyc(IDLE);
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL speed_dn_model got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    total++; if (bus.duty !== 7'd30) begin bad++; $display("FAIL speed_sat_low got=%0d exp=30", bus.duty); end
  endtask

  task automatic test_timer_start();
    int n_inc, tick_at;
    cyc(MOD);
    total++; if (bus.state_code !== 2'd2 || bus.timer_mode !== 1'b1) begin bad++; $display("FAIL tset_enter got=%0d/%0b exp=2/1", bus.state_code, bus.timer_mode); end
    n_inc = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(UPB); n_inc += int'(bus.t_inc);
      cyc(IDLE); n_inc += int'(bus.t_inc);
    end
    total++; if (n_inc != 3) begin bad++; $display("FAIL t_inc_count got=%0d exp=3", n_inc); end
    total++; if (bus.duty !== 7'd30) begin bad++; $display("FAIL tset_speed_kept got=%0d exp=30", bus.duty); end
    cyc(STA);
    total++; if (bus.t_start !== 1'b1) begin bad++; $display("FAIL t_start_pulse got=%0b exp=1", bus.t_start); end
    tick_at = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(IDLE);
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL start_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
      if (bus.tick_1hz === 1'b1 && tick_at == 0) tick_at = k;
    end
    total++; if (tick_at != N) begin bad++; $display("FAIL first_tick_delay got=%0d exp=%0d", tick_at, N); end
    total++; if (bus.state_code !== 2'd3) begin bad++; $display("FAIL trun_enter got=%0d exp=3", bus.state_code); end
  endtask

  task automatic test_expiry();
    int n;
    n = 0;
    while (bus.state_code === 2'd3 && n < 40) begin
      cyc(IDLE);
      n++;
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL expiry_model n=%0d got=%h exp=%h", n, dut_vec(), exp_vec()); end
    end
    total++; if (bus.state_code !== 2'd0 || bus.timer_done !== 1'b1 || bus.timer_mode !== 1'b0) begin
      bad++; $display("FAIL expiry_state got=%0d/%0b/%0b exp=0/1/0", bus.state_code, bus.timer_done, bus.timer_mode);
    end
    cyc(IDLE);
    total++; if (bus.timer_done !== 1'b0 || bus.duty !== 7'd0 || bus.fan_on !== 1'b0) begin
      bad++; $display("FAIL expiry_after got=%0b/%0d/%0b exp=0/0/0", bus.timer_done, bus.duty, bus.fan_on);
    end
  endtask

  task automatic test_cancel();
    int n;
    cyc(PWR); cyc(UPB); cyc(MOD); cyc(UPB); cyc(IDLE); cyc(STA);
    n = 0;
    while (bus.state_code !== 2'd3 && n < 8) begin cyc(IDLE); n++; end
    total++; if (bus.state_code !== 2'd3) begin bad++; $display("FAIL cancel_reach_trun got=%0d exp=3", bus.state_code); end
    cyc(IDLE);
    cyc(MOD);
    total++; if (bus.state_code !== 2'd1 || bus.timer_mode !== 1'b0 || bus.timer_done !== 1'b0) begin
      bad++; $display("FAIL cancel_mode got=%0d/%0b/%0b exp=1/0/0", bus.state_code, bus.timer_mode, bus.timer_done);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(IDLE);
      total++; if (bus.timer_done !== 1'b0 || bus.duty !== 7'd60) begin bad++; $display("FAIL cancel_after got=%0b/%0d exp=0/60", bus.timer_done, bus.duty); end
    end
  endtask

  task automatic test_simultaneous();
    cyc(PWR | MOD);
    total++; if (bus.state_code !== 2'd0) begin bad++; $display("FAIL pwr_mode_same got=%0d exp=0", bus.state_code); end
    cyc(PWR); cyc(IDLE);
    cyc(UPB | DNB); cyc(IDLE);
    total++; if (bus.duty !== 7'd60 || bus.state_code !== 2'd1) begin bad++; $display("FAIL up_dn_same got=%0d/%0d exp=60/1", bus.duty, bus.state_code); end
    cyc(MOD);
    cyc(STA);
    total++; if (bus.t_start !== 1'b1) begin bad++; $display("FAIL zero_start_pulse got=%0b exp=1", bus.t_start); end
    for (int i = 0; i < 5; i++) begin
      cyc(IDLE);
      total++; if (bus.state_code !== 2'd2) begin bad++; $display("FAIL zero_start_stay got=%0d exp=2", bus.state_code); end
    end
    cyc(PWR);
  endtask

  task automatic test_reset_mid();
    int n;
    cyc(PWR); cyc(UPB); cyc(MOD); cyc(UPB); cyc(UPB); cyc(STA);
    n = 0;
    while (bus.state_code !== 2'd3 && n < 8) begin cyc(IDLE); n++; end
    cyc(IDLE); cyc(IDLE);
    total++; if (bus.state_code !== 2'd3 || bus.duty !== 7'd90) begin bad++; $display("FAIL rstmid_setup got=%0d/%0d exp=3/90", bus.state_code, bus.duty); end
    rst = 1'b1;
    cyc(IDLE);
    total++; if (dut_vec() !== 16'h0) begin bad++; $display("FAIL rstmid_outputs got=%h exp=0000", dut_vec()); end
    rst = 1'b0;
    cyc(IDLE);
    cyc(PWR); cyc(IDLE);
    total++; if (bus.duty !== 7'd30) begin bad++; $display("FAIL rstmid_speed got=%0d exp=30", bus.duty); end
  endtask

  task automatic test_random();
    logic [4:0] b;
    for (int i = 0; i < 3000; i++) begin
      b[4] = ($urandom_range(0, 63) == 0);
      b[3] = ($urandom_range(0, 31) == 0);
      b[2] = ($urandom_range(0, 15) == 0);
      b[1] = ($urandom_range(0, 7) == 0);
      b[0] = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 511) == 0);
      cyc(b);
      total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL random_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    {bus.power_btn, bus.mode_btn, bus.start_btn, bus.up_btn, bus.down_btn} = IDLE;
    bus.timer_running = 1'b0;
    tval = 0; trun = 0;
    m_state = 0; m_speed = 1; m_div = 0; m_prev_run = 0;
    {exp_mode, exp_inc, exp_dec, exp_start, exp_tick, exp_fan, exp_done} = '0;
    exp_duty = '0; exp_state = '0;
    test_reset();
    test_speed();
    test_timer_start();
    test_expiry();
    test_cancel();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
